// File: rtl/ram_burst_addr_gen_if.sv
// Command/address bus between the datapath controller and ram_burst_addr_gen.
// The master issues commands and consumes addresses; the slave is the sequencer.
// Optional abort line is present only when RAM_BURST_ADDR_GEN_ABORT_EN is defined.
interface ram_burst_addr_gen_if #(
    parameter int ADDRESS_WIDTH = 14,
    parameter int COUNT_WIDTH   = 15
);
    logic                     start;
    logic [ADDRESS_WIDTH-1:0] base_addr;
    logic [COUNT_WIDTH-1:0]   num_words;
    logic                     wrap_mode;
    logic                     stall;
`ifdef RAM_BURST_ADDR_GEN_ABORT_EN
    logic                     abort;
`endif
    logic [ADDRESS_WIDTH-1:0] ram_addr;
    logic                     addr_valid;
    logic                     burst_last;
    logic                     busy;
    logic                     done;

`ifdef RAM_BURST_ADDR_GEN_ABORT_EN
    modport master (
        output start, base_addr, num_words, wrap_mode, stall, abort,
        input  ram_addr, addr_valid, burst_last, busy, done
    );
    modport slave (
        input  start, base_addr, num_words, wrap_mode, stall, abort,
        output ram_addr, addr_valid, burst_last, busy, done
    );
`else
    modport master (
        output start, base_addr, num_words, wrap_mode, stall,
        input  ram_addr, addr_valid, burst_last, busy, done
    );
    modport slave (
        input  start, base_addr, num_words, wrap_mode, stall,
        output ram_addr, addr_valid, burst_last, busy, done
    );
`endif
endinterface

// File: rtl/ram_burst_addr_gen.sv
// RAM address sequencer: emits num_words addresses from base_addr in linear
// or burst-wrap order, one per non-stalled cycle, then pulses done.
// Optional feature macro: RAM_BURST_ADDR_GEN_ABORT_EN (adds bus.abort).
module ram_burst_addr_gen #(
    parameter int ADDRESS_WIDTH   = 14,
    parameter int MAX_RAM_ADDRESS = 16384,
    parameter int BURST_LEN       = 8,
    parameter int COUNT_WIDTH     = 15
) (
    input logic                 clk,
    input logic                 reset,
    ram_burst_addr_gen_if.slave bus
);
    localparam int BL_W = $clog2(BURST_LEN);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(MAX_RAM_ADDRESS - 1);
    localparam logic [COUNT_WIDTH-1:0]   MAX_COUNT = COUNT_WIDTH'(MAX_RAM_ADDRESS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t                   r_state;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [COUNT_WIDTH-1:0]   r_remaining;
    logic                     r_wrap;
    logic                     r_run;
    logic                     r_busy;
    logic                     r_done;

    logic [ADDRESS_WIDTH-1:0] w_addr_next;
    logic [COUNT_WIDTH-1:0]   w_count_in;
    logic                     w_last_word;
    logic                     w_burst_end;
    logic                     w_abort;

`ifdef RAM_BURST_ADDR_GEN_ABORT_EN
    assign w_abort = bus.abort;
`else
    assign w_abort = 1'b0;
`endif

    // A single sequence never covers more than the whole RAM.
    assign w_count_in  = (bus.num_words > MAX_COUNT) ? MAX_COUNT : bus.num_words;
    assign w_last_word = (r_remaining == COUNT_WIDTH'(1));
    assign w_burst_end = &r_addr[BL_W-1:0];

    // Next address: wrap inside the aligned burst window, or linear with RAM-end wrap.
    always_comb begin
        w_addr_next = r_addr + ADDRESS_WIDTH'(1);
        if (r_wrap) begin
            w_addr_next              = r_addr;
            w_addr_next[BL_W-1:0]    = r_addr[BL_W-1:0] + BL_W'(1);
        end else if (r_addr == LAST_ADDR) begin
            w_addr_next = '0;
        end
    end

    // Only stall gates the live outputs; everything else comes from registers.
    assign bus.ram_addr   = r_addr;
    assign bus.addr_valid = r_run & ~bus.stall;
    assign bus.burst_last = bus.addr_valid & (w_burst_end | w_last_word);
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

    // Sequencer FSM with registered address, count and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_wrap      <= 1'b0;
            r_run       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.num_words != '0) begin
                            r_addr      <= bus.base_addr;
                            r_remaining <= w_count_in;
                            r_wrap      <= bus.wrap_mode;
                            r_run       <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= S_RUN;
                        end else begin
                            // Empty command: straight to completion, no address emitted.
                            r_addr  <= LAST_ADDR;
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_abort || (!bus.stall && w_last_word)) begin
                        r_addr  <= LAST_ADDR;
                        r_run   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end else if (!bus.stall) begin
                        r_remaining <= r_remaining - COUNT_WIDTH'(1);
                        r_addr      <= w_addr_next;
                    end
                end
                S_FIN: begin
                    // Address stays parked at the top of RAM while idle.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_burst_addr_gen.sv
// Bench for ram_burst_addr_gen: directed table, hand sequences for reset and
// abort corners, and random commands checked against an address-list model.
module tb_ram_burst_addr_gen;
    localparam int AW  = 14;
    localparam int CW  = 15;
    localparam int MAX = 16384;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    int q_addr[$];
    bit q_last[$];

    always #5 clk = ~clk;

    ram_burst_addr_gen_if #(.ADDRESS_WIDTH(AW), .COUNT_WIDTH(CW)) bus();

    ram_burst_addr_gen #(
        .ADDRESS_WIDTH(AW), .MAX_RAM_ADDRESS(MAX), .BURST_LEN(8), .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct packed {
        logic [AW-1:0]      base;
        logic [CW-1:0]      nw;
        logic               wrap;
        logic [31:0]        stall_pat;
        int                 n;
        logic [7:0][AW-1:0] a;      // a[0] is the first address
        logic [7:0]         last;   // bit k: burst_last expected on address k
        int                 cyc;    // RUN cycles before done
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    // Expected address list computed straight from the ordering rules.
    task automatic model(input int base, input int nw, input bit wrap);
        int n;
        int a;
        n = (nw > MAX) ? MAX : nw;
        for (int i = 0; i < n; i++) begin
            if (wrap) a = (base & ~7) | ((base + i) & 7);
            else      a = (base + i) % MAX;
            q_addr.push_back(a);
            q_last.push_back(((a % 8) == 7) || (i == n - 1));
        end
    endtask

    // Issue one command (called at posedge+1 in IDLE), scoreboard until done.
    task automatic run_seq(input string nm, input logic [AW-1:0] base, input logic [CW-1:0] nw,
                           input logic wrap, input logic [31:0] pat, input bit rnd,
                           output int cycles);
        bit got_done;
        int budget;
        budget = 8 * int'(nw) + 50;
        bus.start = 1'b1; bus.base_addr = base; bus.num_words = nw;
        bus.wrap_mode = wrap; bus.stall = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cycles = 0;
        got_done = 1'b0;
        while (!got_done) begin
            if (cycles >= budget) begin
                fail_now({nm, " timeout waiting for done"});
                break;
            end
            bus.stall = rnd ? ($urandom_range(0, 3) == 0) : ((cycles < 32) ? pat[cycles] : 1'b0);
            @(negedge clk);
            if (bus.done) begin
                got_done = 1'b1;
                chk({nm, " fin addr"},  32'(bus.ram_addr), 32'(MAX - 1));
                chk({nm, " fin busy"},  32'(bus.busy), 0);
                chk({nm, " fin valid"}, 32'(bus.addr_valid), 0);
            end else begin
                chk({nm, " busy"},  32'(bus.busy), 1);
                chk({nm, " valid"}, 32'(bus.addr_valid), 32'(!bus.stall));
                if (bus.addr_valid) begin
                    if (q_addr.size() == 0) begin
                        fail_now({nm, " extra address"});
                    end else begin
                        chk({nm, " addr"}, 32'(bus.ram_addr), 32'(q_addr.pop_front()));
                        chk({nm, " last"}, 32'(bus.burst_last), 32'(q_last.pop_front()));
                    end
                end else begin
                    chk({nm, " last while invalid"}, 32'(bus.burst_last), 0);
                end
                cycles++;
            end
            @(posedge clk); #1;
        end
        bus.stall = 1'b0;
        chk({nm, " missing addresses"}, 32'(q_addr.size()), 0);
        q_addr.delete();
        q_last.delete();
    endtask

    initial begin
        int cyc;
        logic [AW-1:0] rb;
        logic [CW-1:0] rn;
        logic          rw;

        tbl[0] = '{base:14'd16382, nw:15'd4, wrap:1'b0, stall_pat:32'h0, n:4,
                   a:{14'd0, 14'd0, 14'd0, 14'd0, 14'd1, 14'd0, 14'd16383, 14'd16382},
                   last:8'b0000_1010, cyc:4};
        tbl[1] = '{base:14'd13, nw:15'd8, wrap:1'b1, stall_pat:32'h0, n:8,
                   a:{14'd12, 14'd11, 14'd10, 14'd9, 14'd8, 14'd15, 14'd14, 14'd13},
                   last:8'b1000_0100, cyc:8};
        tbl[2] = '{base:14'd100, nw:15'd3, wrap:1'b0, stall_pat:32'h2, n:3,
                   a:{14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'd102, 14'd101, 14'd100},
                   last:8'b0000_0100, cyc:4};
        tbl[3] = '{base:14'd0, nw:15'd3, wrap:1'b1, stall_pat:32'h0, n:3,
                   a:{14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'd2, 14'd1, 14'd0},
                   last:8'b0000_0100, cyc:3};
        tbl[4] = '{base:14'd6, nw:15'd3, wrap:1'b0, stall_pat:32'h5, n:3,
                   a:{14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'd8, 14'd7, 14'd6},
                   last:8'b0000_0110, cyc:5};
        tbl[5] = '{base:14'd16383, nw:15'd2, wrap:1'b1, stall_pat:32'h0, n:2,
                   a:{14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'd16376, 14'd16383},
                   last:8'b0000_0011, cyc:2};

        reset = 1'b1;
        bus.start = 1'b0; bus.base_addr = '0; bus.num_words = '0;
        bus.wrap_mode = 1'b0; bus.stall = 1'b0;
`ifdef RAM_BURST_ADDR_GEN_ABORT_EN
        bus.abort = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state, and ram_addr stays 0 in IDLE until the first FIN.
        @(negedge clk);
        chk("reset addr",  32'(bus.ram_addr), 0);
        chk("reset busy",  32'(bus.busy), 0);
        chk("reset done",  32'(bus.done), 0);
        chk("reset valid", 32'(bus.addr_valid), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("idle addr after reset", 32'(bus.ram_addr), 0);
        @(posedge clk); #1;

        // Zero-word command: FIN only.
        run_seq("zero-word", 14'd55, 15'd0, 1'b0, 32'h0, 1'b0, cyc);
        chk("zero-word cycles", 32'(cyc), 0);
        @(negedge clk);
        chk("idle park addr", 32'(bus.ram_addr), 32'(MAX - 1));
        chk("idle busy",      32'(bus.busy), 0);
        chk("idle done",      32'(bus.done), 0);
        @(posedge clk); #1;

        // Directed table.
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < tbl[t].n; k++) begin
                q_addr.push_back(int'(tbl[t].a[k]));
                q_last.push_back(tbl[t].last[k]);
            end
            run_seq($sformatf("vec%0d", t), tbl[t].base, tbl[t].nw, tbl[t].wrap,
                    tbl[t].stall_pat, 1'b0, cyc);
            chk($sformatf("vec%0d cycles", t), 32'(cyc), 32'(tbl[t].cyc));
        end

        // Random commands with random stalls against the model.
        for (int i = 0; i < 25; i++) begin
            rb = AW'($urandom_range(0, MAX - 1));
            rn = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 3)) : CW'($urandom_range(1, 40));
            rw = 1'($urandom_range(0, 1));
            model(int'(rb), int'(rn), rw);
            run_seq($sformatf("rand%0d", i), rb, rn, rw, 32'h0, 1'b1, cyc);
        end

        // Oversized count saturates to the whole RAM.
        model(5, 16385, 1'b0);
        run_seq("saturate", 14'd5, 15'd16385, 1'b0, 32'h0, 1'b0, cyc);
        chk("saturate cycles", 32'(cyc), 32'(MAX));

        // Reset mid-RUN, with an ignored start while busy.
        bus.start = 1'b1; bus.base_addr = 14'd0; bus.num_words = 15'd10; bus.wrap_mode = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) begin
            bus.start     = (k == 2);
            bus.base_addr = (k == 2) ? 14'd999 : 14'd0;
            bus.num_words = 15'd5;
            if (k == 5) reset = 1'b1;
            @(negedge clk);
            chk("midrun addr",  32'(bus.ram_addr), 32'(k));
            chk("midrun valid", 32'(bus.addr_valid), 1);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset addr",  32'(bus.ram_addr), 0);
        chk("post-reset busy",  32'(bus.busy), 0);
        chk("post-reset valid", 32'(bus.addr_valid), 0);
        chk("post-reset done",  32'(bus.done), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post-reset no done",  32'(bus.done), 0);
            chk("post-reset no valid", 32'(bus.addr_valid), 0);
        end
        @(posedge clk); #1;

`ifdef RAM_BURST_ADDR_GEN_ABORT_EN
        // Abort after two addresses of a six-word run.
        bus.start = 1'b1; bus.base_addr = 14'd20; bus.num_words = 15'd6; bus.wrap_mode = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("abort addr0", 32'(bus.ram_addr), 20);
        @(posedge clk); #1;
        bus.abort = 1'b1;
        @(negedge clk);
        chk("abort addr1",  32'(bus.ram_addr), 21);
        chk("abort valid1", 32'(bus.addr_valid), 1);
        @(posedge clk); #1;
        bus.abort = 1'b0;
        @(negedge clk);
        chk("abort done",  32'(bus.done), 1);
        chk("abort valid", 32'(bus.addr_valid), 0);
        chk("abort busy",  32'(bus.busy), 0);
        @(negedge clk);
        chk("abort done once", 32'(bus.done), 0);
        chk("abort idle busy", 32'(bus.busy), 0);
        @(posedge clk); #1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
